// File: rtl/id_pkg.sv
// ============================================================================
// Module : id_pkg
// Shared opcodes, control-field layout and decode helpers for the ID stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ex = {reg_dst, alu_src, alu_op[1:0]}, m = {mem_read, mem_write}, wb = {reg_write, mem_to_reg}
  localparam int EX_REG_DST    = 3;
  localparam int EX_ALU_SRC    = 2;
  localparam int M_MEM_READ    = 1;
  localparam int M_MEM_WRITE   = 0;
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  typedef struct packed {
    logic [3:0] ex;
    logic [1:0] m;
    logic [1:0] wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{ex: 4'b0000, m: 2'b00, wb: 2'b00};

  typedef enum logic [2:0] {
    INS_NOP   = 3'd0,
    INS_RTYPE = 3'd1,
    INS_LW    = 3'd2,
    INS_SW    = 3'd3,
    INS_ADDI  = 3'd4,
    INS_BEQ   = 3'd5,
    INS_BNE   = 3'd6,
    INS_J     = 3'd7
  } ins_kind_t;

  function automatic ins_kind_t classify(input logic [5:0] op);
    ins_kind_t k;
    case (op)
      OP_RTYPE: k = INS_RTYPE;
      OP_LW:    k = INS_LW;
      OP_SW:    k = INS_SW;
      OP_ADDI:  k = INS_ADDI;
      OP_BEQ:   k = INS_BEQ;
      OP_BNE:   k = INS_BNE;
      OP_J:     k = INS_J;
      default:  k = INS_NOP;
    endcase
    return k;
  endfunction

  function automatic ctrl_t decode_ctrl(input ins_kind_t k);
    ctrl_t c;
    c = CTRL_NOP;
    case (k)
      INS_RTYPE: begin
        c.ex[EX_REG_DST]   = 1'b1;
        c.ex[1:0]          = ALU_OP_RTYPE;
        c.wb[WB_REG_WRITE] = 1'b1;
      end
      INS_LW: begin
        c.ex[EX_ALU_SRC]    = 1'b1;
        c.ex[1:0]           = ALU_OP_ADD;
        c.m[M_MEM_READ]     = 1'b1;
        c.wb[WB_REG_WRITE]  = 1'b1;
        c.wb[WB_MEM_TO_REG] = 1'b1;
      end
      INS_SW: begin
        c.ex[EX_ALU_SRC] = 1'b1;
        c.m[M_MEM_WRITE] = 1'b1;
      end
      INS_ADDI: begin
        c.ex[EX_ALU_SRC]   = 1'b1;
        c.wb[WB_REG_WRITE] = 1'b1;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

  function automatic logic reads_rt(input ins_kind_t k);
    return (k == INS_RTYPE) || (k == INS_SW) || (k == INS_BEQ) || (k == INS_BNE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_pipelined_if.sv
// ============================================================================
// Module : id_stage_pipelined_if
// IF/ID, WB, MEM and ID/EX signal bundle of the decode stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface id_stage_pipelined_if #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 10,
  parameter int REG_ADDR_W = 5
);
  logic [31:0]           instr_in;
  logic [PC_W-1:0]       pc_in;
  logic                  valid_in;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rw;
  logic [DATA_W-1:0]     wb_busw;
  logic                  mem_we;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_is_load;
  logic [DATA_W-1:0]     mem_result;
  logic                  stall_out;
  logic                  flush_if;
  logic                  pc_sel;
  logic [PC_W-1:0]       branch_target;
  logic                  ex_valid;
  logic [3:0]            ex_ctrl;
  logic [1:0]            m_ctrl;
  logic [1:0]            wb_ctrl;
  logic [DATA_W-1:0]     ex_busa;
  logic [DATA_W-1:0]     ex_busb;
  logic [DATA_W-1:0]     ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [REG_ADDR_W-1:0] ex_rd;

  modport master (
    output instr_in, pc_in, valid_in, wb_we, wb_rw, wb_busw,
           mem_we, mem_rd, mem_is_load, mem_result,
    input  stall_out, flush_if, pc_sel, branch_target, ex_valid, ex_ctrl,
           m_ctrl, wb_ctrl, ex_busa, ex_busb, ex_imm, ex_rs, ex_rt, ex_rd
  );

  modport slave (
    input  instr_in, pc_in, valid_in, wb_we, wb_rw, wb_busw,
           mem_we, mem_rd, mem_is_load, mem_result,
    output stall_out, flush_if, pc_sel, branch_target, ex_valid, ex_ctrl,
           m_ctrl, wb_ctrl, ex_busa, ex_busb, ex_imm, ex_rs, ex_rt, ex_rd
  );
endinterface

`default_nettype wire

// File: rtl/id_hazard_unit.sv
// ============================================================================
// Module : id_hazard_unit
// Load-use / branch-data stall detection and MEM-to-ID branch forward select.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_hazard_unit
  import id_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  ins_kind_t             kind,
  input  logic                  ex_valid,
  input  logic                  ex_reg_dst,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_is_load,
  output logic                  stall,
  output logic                  fwd_a,
  output logic                  fwd_b
);
  logic                  w_is_branch;
  logic                  w_load_use;
  logic                  w_br_haz_a;
  logic                  w_br_haz_b;
  logic [REG_ADDR_W-1:0] w_ex_dst;

  always_comb begin
    w_is_branch = (kind == INS_BEQ) || (kind == INS_BNE);
    w_ex_dst    = ex_reg_dst ? ex_rd : ex_rt;
    w_load_use  = ex_valid && ex_mem_read && (ex_rt != '0) &&
                  ((ex_rt == rs) || ((ex_rt == rt) && reads_rt(kind)));
    // Branches compare in ID, so an EX producer or an in-flight load cannot be forwarded.
    w_br_haz_a  = (rs != '0) &&
                  ((ex_valid && ex_reg_write && (w_ex_dst == rs)) ||
                   (mem_we && mem_is_load && (mem_rd == rs)));
    w_br_haz_b  = (rt != '0) &&
                  ((ex_valid && ex_reg_write && (w_ex_dst == rt)) ||
                   (mem_we && mem_is_load && (mem_rd == rt)));
    stall       = w_load_use || (w_is_branch && (w_br_haz_a || w_br_haz_b));
    fwd_a       = mem_we && !mem_is_load && (rs != '0) && (mem_rd == rs);
    fwd_b       = mem_we && !mem_is_load && (rt != '0) && (mem_rd == rt);
  end
endmodule

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// ============================================================================
// Module : regfile_2r1w
// Two-read one-write register file, r0 hardwired to zero, write-through reads.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_2r1w #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b
);
  logic [DATA_W-1:0] r_mem [2**REG_ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**REG_ADDR_W; i++) r_mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Same-cycle WB write is bypassed so ID never waits on WB.
  always_comb begin
    rdata_a = r_mem[raddr_a];
    rdata_b = r_mem[raddr_b];
    if (we && (waddr == raddr_a)) rdata_a = wdata;
    if (we && (waddr == raddr_b)) rdata_b = wdata;
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
  end
endmodule

`default_nettype wire

// File: rtl/id_stage_pipelined.sv
// ============================================================================
// Module : id_stage_pipelined
// Decode stage: regfile, hazard detection, ID branch resolution, ID/EX register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 10,
  parameter int REG_ADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  id_stage_pipelined_if.slave bus
);
  logic [5:0]            w_op;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [REG_ADDR_W-1:0] w_rd;
  ins_kind_t             w_kind;
  ctrl_t                 w_ctrl;
  logic [DATA_W-1:0]     w_imm;
  logic [DATA_W-1:0]     w_rf_a;
  logic [DATA_W-1:0]     w_rf_b;
  logic [DATA_W-1:0]     w_opa;
  logic [DATA_W-1:0]     w_opb;
  logic                  w_stall;
  logic                  w_fwd_a;
  logic                  w_fwd_b;
  logic                  w_eq;
  logic                  w_taken;
  logic                  w_load;

  logic                  r_ex_valid;
  ctrl_t                 r_ctrl;
  logic [DATA_W-1:0]     r_busa;
  logic [DATA_W-1:0]     r_busb;
  logic [DATA_W-1:0]     r_imm;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic [REG_ADDR_W-1:0] r_rd;

  assign w_op   = bus.instr_in[31:26];
  assign w_rs   = bus.instr_in[21 +: REG_ADDR_W];
  assign w_rt   = bus.instr_in[16 +: REG_ADDR_W];
  assign w_rd   = bus.instr_in[11 +: REG_ADDR_W];
  assign w_kind = classify(w_op);
  assign w_ctrl = decode_ctrl(w_kind);
  assign w_imm  = DATA_W'($signed(bus.instr_in[15:0]));

  regfile_2r1w #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.wb_we),
    .waddr   (bus.wb_rw),
    .wdata   (bus.wb_busw),
    .raddr_a (w_rs),
    .raddr_b (w_rt),
    .rdata_a (w_rf_a),
    .rdata_b (w_rf_b)
  );

  id_hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .rs           (w_rs),
    .rt           (w_rt),
    .kind         (w_kind),
    .ex_valid     (r_ex_valid),
    .ex_reg_dst   (r_ctrl.ex[EX_REG_DST]),
    .ex_mem_read  (r_ctrl.m[M_MEM_READ]),
    .ex_reg_write (r_ctrl.wb[WB_REG_WRITE]),
    .ex_rt        (r_rt),
    .ex_rd        (r_rd),
    .mem_we       (bus.mem_we),
    .mem_rd       (bus.mem_rd),
    .mem_is_load  (bus.mem_is_load),
    .stall        (w_stall),
    .fwd_a        (w_fwd_a),
    .fwd_b        (w_fwd_b)
  );

  assign w_opa   = w_fwd_a ? bus.mem_result : w_rf_a;
  assign w_opb   = w_fwd_b ? bus.mem_result : w_rf_b;
  assign w_eq    = (w_opa == w_opb);
  assign w_taken = bus.valid_in && !w_stall &&
                   ((w_kind == INS_J) ||
                    ((w_kind == INS_BEQ) && w_eq) ||
                    ((w_kind == INS_BNE) && !w_eq));
  assign w_load  = bus.valid_in && !w_stall;

  assign bus.stall_out     = w_stall;
  assign bus.pc_sel        = w_taken;
  assign bus.flush_if      = w_taken;
  assign bus.branch_target = (w_kind == INS_J) ? bus.instr_in[PC_W-1:0]
                                               : bus.pc_in + PC_W'(1) + w_imm[PC_W-1:0];

  // Invalid slots and stalls both enter EX as a fully zeroed bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ctrl     <= CTRL_NOP;
      r_busa     <= '0;
      r_busb     <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
    end else if (w_load) begin
      r_ex_valid <= 1'b1;
      r_ctrl     <= w_ctrl;
      r_busa     <= w_rf_a;
      r_busb     <= w_rf_b;
      r_imm      <= w_imm;
      r_rs       <= w_rs;
      r_rt       <= w_rt;
      r_rd       <= w_rd;
    end else begin
      r_ex_valid <= 1'b0;
      r_ctrl     <= CTRL_NOP;
      r_busa     <= '0;
      r_busb     <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
    end
  end

  assign bus.ex_valid = r_ex_valid;
  assign bus.ex_ctrl  = r_ctrl.ex;
  assign bus.m_ctrl   = r_ctrl.m;
  assign bus.wb_ctrl  = r_ctrl.wb;
  assign bus.ex_busa  = r_busa;
  assign bus.ex_busb  = r_busb;
  assign bus.ex_imm   = r_imm;
  assign bus.ex_rs    = r_rs;
  assign bus.ex_rt    = r_rt;
  assign bus.ex_rd    = r_rd;
endmodule

`default_nettype wire
